// File: rtl/viterbi_tb_packer_pkg.sv
// Shared types for the Viterbi block traceback unit.
// Holds K encodings, the control state enum and the K-to-m mapping.
package viterbi_tb_packer_pkg;

   localparam logic [1:0] CONSTR_LEN_3 = 2'd0;
   localparam logic [1:0] CONSTR_LEN_5 = 2'd1;
   localparam logic [1:0] CONSTR_LEN_7 = 2'd2;
   localparam logic [1:0] CONSTR_LEN_9 = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_WAIT_SEL,
      S_TRACE,
      S_EMIT
   } state_t;

   function automatic logic [3:0] constr_len_to_m(input logic [1:0] c);
      logic [3:0] m;
      case (c)
         CONSTR_LEN_3: m = 4'd2;
         CONSTR_LEN_5: m = 4'd4;
         CONSTR_LEN_7: m = 4'd6;
         default:      m = 4'd8;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/viterbi_tb_packer_out.sv
// Output word packer: slices decoded bits into MSB-first words.
// Handles zero padding, valid/ready holding, last flag and done pulse.
module tb_out_packer #(
   parameter int MAX_STEPS = 64,
   parameter int OUT_W     = 8,
   parameter int LW        = $clog2(MAX_STEPS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [MAX_STEPS-1:0] i_bits,
   input  logic [LW-1:0]        i_len,
   input  logic                 i_ready,
   output logic [OUT_W-1:0]     o_data,
   output logic                 o_valid,
   output logic                 o_last,
   output logic                 o_done
);

   localparam int BW = $clog2(MAX_STEPS);

   logic [LW-1:0]    r_wp;
   logic [OUT_W-1:0] r_data;
   logic             r_valid;
   logic             r_last;
   logic             r_done;
   logic [LW-1:0]    w_wp;
   logic [LW-1:0]    w_nw;
   logic [OUT_W-1:0] w_word;
   int               b;

   always_comb begin
      w_wp   = i_start ? '0 : r_wp + LW'(1);
      w_nw   = LW'((int'(i_len) + OUT_W - 1) / OUT_W);
      w_word = '0;
      b      = 0;
      for (int j = 0; j < OUT_W; j++) begin
         b = int'(w_wp) * OUT_W + j;
         if (b < int'(i_len))
            w_word[OUT_W-1-j] = i_bits[b[BW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp    <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_wp    <= '0;
            r_data  <= w_word;
            r_valid <= 1'b1;
            r_last  <= (w_nw == LW'(1));
         end else if (r_valid && i_ready) begin
            if (r_last) begin
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_data  <= '0;
               r_done  <= 1'b1;
            end else begin
               r_wp   <= w_wp;
               r_data <= w_word;
               r_last <= ((w_wp + LW'(1)) == w_nw);
            end
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_last  = r_last;
   assign o_done  = r_done;

endmodule

// File: rtl/viterbi_tb_packer.sv
// Block-mode Viterbi traceback: stores decisions, traces back from
// the best end state and streams decoded bits in forward order.
module viterbi_tb_packer
   import viterbi_tb_packer_pkg::*;
#(
   parameter int MAX_K      = 9,
   parameter int STATE_BITS = MAX_K - 1,
   parameter int NUM_STATES = 1 << STATE_BITS,
   parameter int MAX_STEPS  = 64,
   parameter int OUT_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            i_constr_len,
   input  logic                  i_dec_valid,
   input  logic [NUM_STATES-1:0] i_dec_vec,
   input  logic                  i_last,
   output logic                  o_ready_in,
   input  logic                  i_sel_valid,
   input  logic [STATE_BITS-1:0] i_sel_node,
   output logic [OUT_W-1:0]      o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_last,
   output logic                  o_done,
   output logic                  o_overflow
);

   localparam int PW = $clog2(MAX_STEPS + 1);
   localparam int IW = $clog2(MAX_STEPS);

   state_t                r_state;
   logic [3:0]            r_m;
   logic [PW-1:0]         r_wp;
   logic [PW-1:0]         r_len;
   logic [IW-1:0]         r_idx;
   logic [STATE_BITS-1:0] r_cur;
   logic [MAX_STEPS-1:0]  r_bits;
   logic                  r_rdy;
   logic                  r_ovf;
   logic                  r_start;
   logic [NUM_STATES-1:0] r_mem [MAX_STEPS];

   logic                  w_acc;
   logic                  w_room;
   logic                  w_d;
   logic [STATE_BITS-1:0] w_mask;
   logic [STATE_BITS-1:0] w_cur_nx;
   logic                  w_hs_last;

   assign w_acc    = i_dec_valid & r_rdy;
   assign w_room   = r_wp < PW'(MAX_STEPS);
   assign w_mask   = ~({STATE_BITS{1'b1}} << r_m);
   assign w_d      = r_mem[r_idx][r_cur];
   assign w_cur_nx = ((r_cur >> 1)
                   | (STATE_BITS'(w_d) << (r_m - 4'd1))) & w_mask;
   assign w_hs_last = o_valid & i_ready & o_last;

   // Survivor memory carries no reset; only written vectors are ever read.
   always_ff @(posedge clk) begin
      if (w_acc && w_room)
         r_mem[r_wp[IW-1:0]] <= i_dec_vec;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_m     <= 4'd2;
         r_wp    <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_cur   <= '0;
         r_bits  <= '0;
         r_rdy   <= 1'b0;
         r_ovf   <= 1'b0;
         r_start <= 1'b0;
      end else begin
         r_start <= 1'b0;
         unique case (r_state)
            S_IDLE, S_FILL: begin
               r_rdy <= 1'b1;
               if (w_acc) begin
                  if (r_state == S_IDLE)
                     r_m <= constr_len_to_m(i_constr_len);
                  if (w_room)
                     r_wp <= r_wp + PW'(1);
                  else
                     r_ovf <= 1'b1;
                  r_state <= S_FILL;
                  if (i_last) begin
                     r_len   <= r_wp + PW'(w_room);
                     r_rdy   <= 1'b0;
                     r_state <= S_WAIT_SEL;
                  end
               end
            end
            S_WAIT_SEL: begin
               if (i_sel_valid) begin
                  r_cur   <= i_sel_node & w_mask;
                  r_idx   <= IW'(r_len - PW'(1));
                  r_state <= S_TRACE;
               end
            end
            S_TRACE: begin
               r_bits[r_idx] <= r_cur[0];
               r_cur         <= w_cur_nx;
               r_idx         <= r_idx - IW'(1);
               if (r_idx == '0) begin
                  r_start <= 1'b1;
                  r_state <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (w_hs_last) begin
                  r_wp    <= '0;
                  r_rdy   <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   tb_out_packer #(
      .MAX_STEPS (MAX_STEPS),
      .OUT_W     (OUT_W),
      .LW        (PW)
   ) u_pack (
      .clk     (clk),
      .rst     (rst),
      .i_start (r_start),
      .i_bits  (r_bits),
      .i_len   (r_len),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_last  (o_last),
      .o_done  (o_done)
   );

   assign o_ready_in = r_rdy;
   assign o_overflow = r_ovf;

endmodule
